// File: rtl/regfile_mp.sv
// regfile_mp: NREG x WIDTH register file with pending bits; ports clk, reset_n, data_in/write/writenum, reserve/reservenum, readnum_a/b -> registered data_out_a/b, pend_a/b, pend_count
module regfile_mp #(
    parameter int WIDTH   = 16,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic [AW-1:0]    writenum,
    input  logic             reserve,
    input  logic [AW-1:0]    reservenum,
    input  logic [AW-1:0]    readnum_a,
    input  logic [AW-1:0]    readnum_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             pend_a,
    output logic             pend_b,
    output logic [AW:0]      pend_count
);
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]  pend_q, pend_d;
    logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
    logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [AW:0]      cnt_q, cnt_d;
    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        data_a_d = '0;
        data_b_d = '0;
        pend_a_d = 1'b0;
        pend_b_d = 1'b0;
        cnt_d    = '0;
        for (int i = 0; i < NREG; i++) begin
            if (write && writenum == AW'(i)) begin
                regs_d[i] = data_in;
                pend_d[i] = 1'b0;
            end
            if (reserve && reservenum == AW'(i)) pend_d[i] = 1'b1;
        end
        if (ZERO_R0 != 0) begin
            regs_d[0] = '0;
            pend_d[0] = 1'b0;
        end
        for (int i = 0; i < NREG; i++) begin
            if (readnum_a == AW'(i)) begin
                data_a_d = regs_d[i];
                pend_a_d = pend_d[i];
            end
            if (readnum_b == AW'(i)) begin
                data_b_d = regs_d[i];
                pend_b_d = pend_d[i];
            end
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_q   <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            cnt_q    <= cnt_d;
        end
    end
    assign data_out_a = data_a_q;
    assign data_out_b = data_b_q;
    assign pend_a     = pend_a_q;
    assign pend_b     = pend_b_q;
    assign pend_count = cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks a default regfile_mp and a ZERO_R0=1/NREG=6 variant against a behavioural model
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic            reset_n, write, reserve;
    logic [15:0]     data_in;
    logic [2:0]      writenum, reservenum, readnum_a, readnum_b;
    logic [1:0][15:0] doa, dob;
    logic [1:0]      pa, pb;
    logic [1:0][3:0] pc;
    int checks = 0, errors = 0;
    logic [15:0] mem [2][8];
    logic [7:0]  pend [2];
    regfile_mp #(.WIDTH(16), .NREG(8), .AW(3), .ZERO_R0(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .write(write), .writenum(writenum),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(doa[0]), .data_out_b(dob[0]), .pend_a(pa[0]), .pend_b(pb[0]), .pend_count(pc[0]));
    regfile_mp #(.WIDTH(16), .NREG(6), .AW(3), .ZERO_R0(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .write(write), .writenum(writenum),
        .reserve(reserve), .reservenum(reservenum), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(doa[1]), .data_out_b(dob[1]), .pend_a(pa[1]), .pend_b(pb[1]), .pend_count(pc[1]));
    typedef struct {
        logic        rst_n, w;
        logic [2:0]  wn;
        logic [15:0] d;
        logic        r;
        logic [2:0]  rn, ra, rb;
        logic [15:0] ea;
        logic        epa;
        logic [15:0] eb;
        logic        epb;
        logic [3:0]  ecnt;
    } vec_t;
    vec_t tbl [22];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input logic rst_n, input logic w, input logic [2:0] wn, input logic [15:0] d,
                        input logic r, input logic [2:0] rnum, input logic [2:0] ra, input logic [2:0] rb);
        @(negedge clk);
        reset_n = rst_n; write = w; writenum = wn; data_in = d;
        reserve = r; reservenum = rnum; readnum_a = ra; readnum_b = rb;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int n = (k == 1) ? 6 : 8;
            bit z = (k == 1);
            if (!rst_n) begin
                for (int j = 0; j < 8; j++) mem[k][j] = '0;
                pend[k] = '0;
            end else begin
                if (w && wn < n && !(z && wn == 0)) begin
                    mem[k][wn] = d;
                    pend[k][wn] = 1'b0;
                end
                if (r && rnum < n && !(z && rnum == 0)) pend[k][rnum] = 1'b1;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            int n = (k == 1) ? 6 : 8;
            chk($sformatf("dut%0d data_a", k), 32'(doa[k]), 32'((ra < n) ? mem[k][ra] : 16'h0));
            chk($sformatf("dut%0d data_b", k), 32'(dob[k]), 32'((rb < n) ? mem[k][rb] : 16'h0));
            chk($sformatf("dut%0d pend_a", k), 32'(pa[k]), 32'((ra < n) ? pend[k][ra] : 1'b0));
            chk($sformatf("dut%0d pend_b", k), 32'(pb[k]), 32'((rb < n) ? pend[k][rb] : 1'b0));
            chk($sformatf("dut%0d pend_count", k), 32'(pc[k]), 32'($countones(pend[k])));
        end
    endtask
    initial begin
        int c;
        reset_n = 1'b0; write = 1'b0; reserve = 1'b0; data_in = '0;
        writenum = '0; reservenum = '0; readnum_a = '0; readnum_b = '0;
        for (int j = 0; j < 8; j++) begin
            mem[0][j] = '0;
            mem[1][j] = '0;
        end
        pend[0] = '0;
        pend[1] = '0;
        //           rst w  wn  d        r  rn ra rb  ea       pa  eb       pb  cnt
        tbl[0]  = '{0, 1, 1, 16'h5555, 1, 1, 1, 1, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[1]  = '{1, 1, 3, 16'h1234, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[2]  = '{1, 0, 0, 16'h0000, 0, 0, 3, 0, 16'h1234, 0, 16'h0000, 0, 0};
        tbl[3]  = '{1, 1, 5, 16'hBEEF, 0, 0, 5, 5, 16'hBEEF, 0, 16'hBEEF, 0, 0};
        tbl[4]  = '{1, 0, 0, 16'h0000, 1, 2, 2, 3, 16'h0000, 1, 16'h1234, 0, 1};
        tbl[5]  = '{1, 0, 0, 16'h0000, 1, 6, 6, 2, 16'h0000, 1, 16'h0000, 1, 2};
        tbl[6]  = '{1, 0, 0, 16'h0000, 1, 6, 6, 5, 16'h0000, 1, 16'hBEEF, 0, 2};
        tbl[7]  = '{1, 1, 2, 16'h0007, 0, 0, 2, 6, 16'h0007, 0, 16'h0000, 1, 1};
        tbl[8]  = '{1, 1, 4, 16'hAAAA, 1, 4, 4, 4, 16'hAAAA, 1, 16'hAAAA, 1, 2};
        tbl[9]  = '{1, 1, 0, 16'hFFFF, 1, 1, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 3};
        tbl[10] = '{1, 0, 0, 16'h0000, 1, 4, 4, 0, 16'hAAAA, 1, 16'hFFFF, 0, 3};
        tbl[11] = '{1, 1, 1, 16'h1111, 0, 0, 1, 3, 16'h1111, 0, 16'h1234, 0, 2};
        tbl[12] = '{1, 0, 0, 16'h0000, 1, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF, 1, 3};
        tbl[13] = '{1, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h1111, 1, 16'h1111, 1, 4};
        tbl[14] = '{1, 0, 0, 16'h0000, 1, 2, 2, 2, 16'h0007, 1, 16'h0007, 1, 5};
        tbl[15] = '{1, 0, 0, 16'h0000, 1, 3, 3, 3, 16'h1234, 1, 16'h1234, 1, 6};
        tbl[16] = '{1, 0, 0, 16'h0000, 1, 4, 4, 4, 16'hAAAA, 1, 16'hAAAA, 1, 6};
        tbl[17] = '{1, 0, 0, 16'h0000, 1, 5, 5, 5, 16'hBEEF, 1, 16'hBEEF, 1, 7};
        tbl[18] = '{1, 0, 0, 16'h0000, 1, 6, 6, 6, 16'h0000, 1, 16'h0000, 1, 7};
        tbl[19] = '{1, 0, 0, 16'h0000, 1, 7, 7, 7, 16'h0000, 1, 16'h0000, 1, 8};
        tbl[20] = '{0, 1, 1, 16'h5555, 1, 1, 1, 7, 16'h0000, 0, 16'h0000, 0, 0};
        tbl[21] = '{1, 0, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0};
        repeat (2) @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            vec_t v = tbl[i];
            step(v.rst_n, v.w, v.wn, v.d, v.r, v.rn, v.ra, v.rb);
            chk($sformatf("vec%0d data_a", i), 32'(doa[0]), 32'(v.ea));
            chk($sformatf("vec%0d pend_a", i), 32'(pa[0]), 32'(v.epa));
            chk($sformatf("vec%0d data_b", i), 32'(dob[0]), 32'(v.eb));
            chk($sformatf("vec%0d pend_b", i), 32'(pb[0]), 32'(v.epb));
            chk($sformatf("vec%0d pend_count", i), 32'(pc[0]), 32'(v.ecnt));
        end
        step(1, 0, 0, 16'h0, 1, 3, 3, 0);
        c = $countones(pend[1]);
        step(1, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        chk("zr0 data_a", 32'(doa[1]), 32'h0);
        chk("zr0 pend_a", 32'(pa[1]), 32'h0);
        chk("zr0 pend_count", 32'(pc[1]), 32'(c));
        step(1, 1, 7, 16'h1357, 1, 7, 7, 7);
        chk("oor data_a", 32'(doa[1]), 32'h0);
        chk("oor pend_b", 32'(pb[1]), 32'h0);
        chk("oor pend_count", 32'(pc[1]), 32'(c));
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
